execute_mem_storebuf_p: RTL and testbench
=========================================

Name: execute_mem_storebuf_p

Overview:
- Parametrised store buffer for the memory execute path.
- Holds stores from the mem execute stage speculatively, promotes them in order on ROB store commit, and drains committed stores to the wbmem write port.
- Gives the load path a word-address conflict query and an uncached-busy flag.
- Flushes all uncommitted entries on branch-correction (bco_valid). Supersedes the fixed single-entry store handling in the mem execute path.

Parameters:
DEPTH, 4, entry count; power of two, >=2
PTR_W, $clog2(DEPTH), index width; pointers are PTR_W+1 bits for wrap detection
QUERY_COMMITTED_ONLY, 0, 1: s_busy considers only committed entries; 0: all valid entries

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active-high
bco_valid  in  1  flush all uncommitted (speculative) entries
i_valid  in  1  enqueue store this cycle
i_addr  in  32  store byte address
i_strb  in  4  byte strobe
i_lswidth  in  2  access width code, passed through
i_data  in  32  store data, lane-aligned
i_uncached  in  1  uncached store
o_ready  out  1  buffer not full
i_commit_en_store  in  1  commit oldest speculative entry
o_commit_readyn  out  1  high when no speculative entry exists
i_wbmem_en  in  1  downstream accepts head entry
o_wbmem_valid  out  1  head entry committed and presentable
o_wbmem_addr  out  32  head address
o_wbmem_strb  out  4  head strobe
o_wbmem_lswidth  out  2  head width
o_wbmem_data  out  32  head data
o_wbmem_uncached  out  1  head uncached flag
s_qaddr  in  32  load address query
s_busy  out  1  query conflicts with a buffered store
s_o_busy_uncached  out  1  any valid uncached entry
o_count  out  PTR_W+1  occupancy

Behaviour:
- Storage: circular array plus three pointers, each PTR_W+1 bits: head (oldest), cmt (first speculative), tail (next free).
- Committed region = [head, cmt). Speculative region = [cmt, tail). Invariant: head <= cmt <= tail (modular).
- Reset: head = cmt = tail = 0. All entry payloads cleared.
  - Reset-state outputs: o_ready=1, o_commit_readyn=1, o_wbmem_valid=0, o_wbmem_* all 0, s_busy=0, s_o_busy_uncached=0, o_count=0.
  - Reset mid-operation discards all entries, committed ones included.
- Full: tail-head == DEPTH, i.e. index bits equal and wrap bit differs. Empty: tail == head.
- o_ready = !full. It is combinational from the registered pointers only; a drain in the same cycle does not raise it.
- Enqueue when i_valid && o_ready && !bco_valid: write entry[tail], tail++.
  - i_valid while full: dropped silently. The upstream stage must not issue while o_ready is low.
- Commit when i_commit_en_store && cmt != tail: cmt++.
  - Commit with no speculative entry: ignored. o_commit_readyn=1 flags this case.
- Drain: o_wbmem_valid = (head != cmt). o_wbmem_* are driven combinationally from entry[head].
  - On o_wbmem_valid && i_wbmem_en: head++.
  - Payload must stay stable while valid and not accepted.
- Flush: on bco_valid, tail <= cmt_next, where cmt_next includes a same-cycle commit.
  - Same-cycle enqueue is dropped. Committed entries are never flushed.
- Simultaneous events in one cycle:
  - Enqueue + commit + drain all take effect.
  - Commit of an entry enqueued this same cycle is not permitted; cmt compares against the registered tail.
- Query: s_busy = OR over entries e in the region of (e.addr[31:2] == s_qaddr[31:2]).
  - Region = [head, tail) when QUERY_COMMITTED_ONLY=0, else [head, cmt).
  - Purely combinational from current state; the same-cycle enqueue is not visible.
- s_o_busy_uncached = OR of uncached over [head, tail).
- o_count = tail - head, computed modulo 2^(PTR_W+1).
- Wrap-around: pointer indices wrap modulo DEPTH. The wrap bit toggles on each wrap; no reset of pointers on wrap.

Test Plan:
- Reset, then 1 store (addr 0x100, data 0xA5A5A5A5, strb 0xF), then commit, i_wbmem_en=1 -> o_wbmem_valid rises the cycle after commit with addr 0x100, data 0xA5A5A5A5; o_count returns 1->0; o_commit_readyn=1 throughout except while entry speculative.
- DEPTH=4: enqueue 4 stores without commit -> o_ready=0, o_count=4; 5th i_valid dropped; commit 2, drain 2 -> o_ready=1, o_count=2.
- Enqueue 3, commit 1, assert bco_valid together with a commit and an enqueue -> tail=cmt=2, the enqueue lost, o_count=2, o_commit_readyn=1; both committed entries drain in order.
- Store at 0x204 buffered; s_qaddr=0x206 -> s_busy=1; s_qaddr=0x208 -> s_busy=0. With QUERY_COMMITTED_ONLY=1 and the entry uncommitted -> s_busy=0.
- Uncached store enqueued -> s_o_busy_uncached=1 until its drain handshake, then 0. Hold i_wbmem_en=0 for 5 cycles -> wbmem payload stable.
- Stream 10 store/commit/drain cycles through DEPTH=4 -> pointers wrap twice; data order preserved; o_count never exceeds 4. Assert reset mid-stream -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/execute_mem_storebuf_p.sv
// Store buffer for the memory execute path. It holds speculative stores, promotes them
// in order on ROB commit, and drains committed stores to the wbmem write port.
module execute_mem_storebuf_p #(
    parameter int DEPTH                = 4,
    parameter int PTR_W                = $clog2(DEPTH),
    parameter bit QUERY_COMMITTED_ONLY = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bco_valid,
    input  logic             i_valid,
    input  logic [31:0]      i_addr,
    input  logic [3:0]       i_strb,
    input  logic [1:0]       i_lswidth,
    input  logic [31:0]      i_data,
    input  logic             i_uncached,
    output logic             o_ready,
    input  logic             i_commit_en_store,
    output logic             o_commit_readyn,
    input  logic             i_wbmem_en,
    output logic             o_wbmem_valid,
    output logic [31:0]      o_wbmem_addr,
    output logic [3:0]       o_wbmem_strb,
    output logic [1:0]       o_wbmem_lswidth,
    output logic [31:0]      o_wbmem_data,
    output logic             o_wbmem_uncached,
    input  logic [31:0]      s_qaddr,
    output logic             s_busy,
    output logic             s_o_busy_uncached,
    output logic [PTR_W:0]   o_count
);

    typedef logic [PTR_W:0] ptr_t;

    ptr_t        r_head, r_cmt, r_tail;
    logic [31:0] r_addr     [DEPTH];
    logic [3:0]  r_strb     [DEPTH];
    logic [1:0]  r_lswidth  [DEPTH];
    logic [31:0] r_data     [DEPTH];
    logic        r_uncached [DEPTH];

    ptr_t w_count, w_ncmt, w_cmt_next, w_tail_next;
    logic w_full, w_enq, w_cmt, w_drain;
    logic w_busy_all, w_busy_cmt, w_busy_unc;
    logic [PTR_W-1:0] w_hidx;

    assign w_count = r_tail - r_head;
    assign w_ncmt  = r_cmt - r_head;
    assign w_full  = (w_count == ptr_t'(DEPTH));
    assign w_hidx  = r_head[PTR_W-1:0];

    assign w_enq   = i_valid && !w_full && !bco_valid;
    // Commit looks at the registered tail, so a same-cycle enqueue cannot be committed.
    assign w_cmt   = i_commit_en_store && (r_cmt != r_tail);
    assign w_drain = o_wbmem_valid && i_wbmem_en;

    assign w_cmt_next  = r_cmt + ptr_t'(w_cmt);
    assign w_tail_next = bco_valid ? w_cmt_next : (r_tail + ptr_t'(w_enq));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head <= '0;
            r_cmt  <= '0;
            r_tail <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i]     <= '0;
                r_strb[i]     <= '0;
                r_lswidth[i]  <= '0;
                r_data[i]     <= '0;
                r_uncached[i] <= 1'b0;
            end
        end else begin
            r_head <= r_head + ptr_t'(w_drain);
            r_cmt  <= w_cmt_next;
            r_tail <= w_tail_next;
            if (w_enq) begin
                r_addr[r_tail[PTR_W-1:0]]     <= i_addr;
                r_strb[r_tail[PTR_W-1:0]]     <= i_strb;
                r_lswidth[r_tail[PTR_W-1:0]]  <= i_lswidth;
                r_data[r_tail[PTR_W-1:0]]     <= i_data;
                r_uncached[r_tail[PTR_W-1:0]] <= i_uncached;
            end
        end
    end

    // Region membership uses the entry's distance from head, which handles wrap and full.
    always_comb begin
        logic [PTR_W-1:0] w_off;
        logic             w_hit;
        w_off      = '0;
        w_hit      = 1'b0;
        w_busy_all = 1'b0;
        w_busy_cmt = 1'b0;
        w_busy_unc = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off = PTR_W'(i) - w_hidx;
            w_hit = (r_addr[i][31:2] == s_qaddr[31:2]);
            if ({1'b0, w_off} < w_count) begin
                w_busy_all = w_busy_all | w_hit;
                w_busy_unc = w_busy_unc | r_uncached[i];
            end
            if ({1'b0, w_off} < w_ncmt) begin
                w_busy_cmt = w_busy_cmt | w_hit;
            end
        end
    end

    assign o_ready           = !w_full;
    assign o_commit_readyn   = (r_cmt == r_tail);
    assign o_wbmem_valid     = (r_head != r_cmt);
    assign o_wbmem_addr      = r_addr[w_hidx];
    assign o_wbmem_strb      = r_strb[w_hidx];
    assign o_wbmem_lswidth   = r_lswidth[w_hidx];
    assign o_wbmem_data      = r_data[w_hidx];
    assign o_wbmem_uncached  = r_uncached[w_hidx];
    assign s_busy            = QUERY_COMMITTED_ONLY ? w_busy_cmt : w_busy_all;
    assign s_o_busy_uncached = w_busy_unc;
    assign o_count           = w_count;

endmodule

// File: tb/tb_execute_mem_storebuf_p.sv
// Randomised bench for the store buffer: a queue-based reference model plus a drain scoreboard.
module tb_execute_mem_storebuf_p;

    localparam int DEPTH = 4;
    localparam int PTR_W = $clog2(DEPTH);

    logic clk = 1'b0;
    logic reset, bco_valid, i_valid, i_uncached, i_commit_en_store, i_wbmem_en;
    logic [31:0] i_addr, i_data, s_qaddr;
    logic [3:0]  i_strb;
    logic [1:0]  i_lswidth;

    logic o_ready, o_commit_readyn, o_wbmem_valid, o_wbmem_uncached, s_busy, s_o_busy_uncached;
    logic [31:0] o_wbmem_addr, o_wbmem_data;
    logic [3:0]  o_wbmem_strb;
    logic [1:0]  o_wbmem_lswidth;
    logic [PTR_W:0] o_count;

    logic c_ready, c_commit_readyn, c_wbmem_valid, c_wbmem_uncached, c_busy, c_busy_unc;
    logic [31:0] c_wbmem_addr, c_wbmem_data;
    logic [3:0]  c_wbmem_strb;
    logic [1:0]  c_wbmem_lswidth;
    logic [PTR_W:0] c_count;

    always #5 clk = ~clk;

    execute_mem_storebuf_p #(.DEPTH(DEPTH), .QUERY_COMMITTED_ONLY(1'b0)) u_dut (
        .clk(clk), .reset(reset), .bco_valid(bco_valid), .i_valid(i_valid),
        .i_addr(i_addr), .i_strb(i_strb), .i_lswidth(i_lswidth), .i_data(i_data),
        .i_uncached(i_uncached), .o_ready(o_ready), .i_commit_en_store(i_commit_en_store),
        .o_commit_readyn(o_commit_readyn), .i_wbmem_en(i_wbmem_en), .o_wbmem_valid(o_wbmem_valid),
        .o_wbmem_addr(o_wbmem_addr), .o_wbmem_strb(o_wbmem_strb), .o_wbmem_lswidth(o_wbmem_lswidth),
        .o_wbmem_data(o_wbmem_data), .o_wbmem_uncached(o_wbmem_uncached), .s_qaddr(s_qaddr),
        .s_busy(s_busy), .s_o_busy_uncached(s_o_busy_uncached), .o_count(o_count)
    );

    execute_mem_storebuf_p #(.DEPTH(DEPTH), .QUERY_COMMITTED_ONLY(1'b1)) u_dut_c (
        .clk(clk), .reset(reset), .bco_valid(bco_valid), .i_valid(i_valid),
        .i_addr(i_addr), .i_strb(i_strb), .i_lswidth(i_lswidth), .i_data(i_data),
        .i_uncached(i_uncached), .o_ready(c_ready), .i_commit_en_store(i_commit_en_store),
        .o_commit_readyn(c_commit_readyn), .i_wbmem_en(i_wbmem_en), .o_wbmem_valid(c_wbmem_valid),
        .o_wbmem_addr(c_wbmem_addr), .o_wbmem_strb(c_wbmem_strb), .o_wbmem_lswidth(c_wbmem_lswidth),
        .o_wbmem_data(c_wbmem_data), .o_wbmem_uncached(c_wbmem_uncached), .s_qaddr(s_qaddr),
        .s_busy(c_busy), .s_o_busy_uncached(c_busy_unc), .o_count(c_count)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [1:0]  lsw;
        logic [31:0] data;
        logic        unc;
    } ent_t;

    ent_t mq[$];   // buffer contents, oldest first; first ncmt entries are committed
    ent_t sb[$];   // committed stores awaiting their drain handshake
    int   ncmt = 0;
    int   checks = 0;
    int   errors = 0;
    ent_t me;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic check_all(input logic [31:0] q, input bit after_rst);
        logic eb_all, eb_cmt, eunc;
        s_qaddr = q;
        #1;
        eb_all = 1'b0;
        eb_cmt = 1'b0;
        eunc   = 1'b0;
        for (int k = 0; k < mq.size(); k++) begin
            if (mq[k].addr[31:2] == q[31:2]) begin
                eb_all = 1'b1;
                if (k < ncmt) eb_cmt = 1'b1;
            end
            if (mq[k].unc) eunc = 1'b1;
        end
        chk("o_ready", o_ready, mq.size() < DEPTH);
        chk("o_commit_readyn", o_commit_readyn, ncmt == mq.size());
        chk("o_wbmem_valid", o_wbmem_valid, ncmt > 0);
        chk("o_count", o_count, mq.size());
        chk("s_busy_all", s_busy, eb_all);
        chk("s_busy_cmt", c_busy, eb_cmt);
        chk("s_o_busy_uncached", s_o_busy_uncached, eunc);
        if (ncmt > 0) begin
            chk("head_addr", o_wbmem_addr, mq[0].addr);
            chk("head_data", o_wbmem_data, mq[0].data);
        end
        if (after_rst) begin
            chk("rst_addr", o_wbmem_addr, 32'h0);
            chk("rst_data", o_wbmem_data, 32'h0);
            chk("rst_strb", o_wbmem_strb, 32'h0);
            chk("rst_lsw", o_wbmem_lswidth, 32'h0);
            chk("rst_unc", o_wbmem_uncached, 32'h0);
        end
    endtask

    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [1:0] w, input logic u,
                        input logic cm, input logic wb, input logic bco, input logic rst,
                        input logic [31:0] q);
        ent_t e;
        bit enq, cmt, dr;
        reset = rst; i_valid = v; i_addr = a; i_data = d; i_strb = s; i_lswidth = w;
        i_uncached = u; i_commit_en_store = cm; i_wbmem_en = rst ? 1'b0 : wb; bco_valid = bco;
        if (rst) begin
            mq.delete();
            sb.delete();
            ncmt = 0;
        end else begin
            enq = v && (mq.size() < DEPTH) && !bco;
            cmt = cm && (ncmt < mq.size());
            dr  = wb && (ncmt > 0);
            if (cmt) begin
                sb.push_back(mq[ncmt]);
                ncmt++;
            end
            if (dr) begin
                void'(mq.pop_front());
                ncmt--;
            end
            if (bco) while (mq.size() > ncmt) void'(mq.pop_back());
            if (enq) begin
                e.addr = a; e.strb = s; e.lsw = w; e.data = d; e.unc = u;
                mq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        check_all(q, rst);
    endtask

    task automatic idle(input logic cm, input logic wb, input logic [31:0] q);
        step(1'b0, 32'h0, 32'h0, 4'h0, 2'd0, 1'b0, cm, wb, 1'b0, 1'b0, q);
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d, input logic u,
                      input logic cm, input logic wb, input logic [31:0] q);
        step(1'b1, a, d, 4'hF, 2'd2, u, cm, wb, 1'b0, 1'b0, q);
    endtask

    task automatic drain_all();
        for (int k = 0; k < 40 && mq.size() > 0; k++) idle(1'b1, 1'b1, 32'h0);
        chk("drain_all_empty", mq.size(), 0);
    endtask

    // Drain monitor: every wbmem handshake must match the oldest committed store.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && o_wbmem_valid && i_wbmem_en) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL drain_unexpected: got addr %h expected no handshake", o_wbmem_addr);
                end else begin
                    me = sb.pop_front();
                    chk("drain_addr", o_wbmem_addr, me.addr);
                    chk("drain_data", o_wbmem_data, me.data);
                    chk("drain_strb", o_wbmem_strb, me.strb);
                    chk("drain_lsw", o_wbmem_lswidth, me.lsw);
                    chk("drain_unc", o_wbmem_uncached, me.unc);
                end
            end
        end
    end

    initial begin
        logic [31:0] ra, rq;
        s_qaddr = 32'h0;
        step(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 32'h0);
        step(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 32'h100);

        // single store, commit, drain
        st(32'h100, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b1, 32'h100);
        idle(1'b1, 1'b1, 32'h100);
        idle(1'b0, 1'b1, 32'h100);
        idle(1'b0, 1'b1, 32'h100);

        // fill, drop the fifth, commit and drain two
        for (int k = 0; k < 5; k++) st(32'h300 + 4 * k, 32'h1000 + k, 1'b0, 1'b0, 1'b0, 32'h300);
        idle(1'b1, 1'b0, 32'h0);
        idle(1'b1, 1'b0, 32'h0);
        idle(1'b0, 1'b1, 32'h0);
        idle(1'b0, 1'b1, 32'h0);
        drain_all();

        // flush with same-cycle commit and enqueue
        for (int k = 0; k < 3; k++) st(32'h400 + 4 * k, 32'h2000 + k, 1'b0, 1'b0, 1'b0, 32'h0);
        idle(1'b1, 1'b0, 32'h0);
        step(1'b1, 32'h4FC, 32'hDEAD, 4'hF, 2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h4FC);
        drain_all();

        // word-address query, speculative then committed
        st(32'h204, 32'h55, 1'b0, 1'b0, 1'b0, 32'h206);
        idle(1'b0, 1'b0, 32'h206);
        idle(1'b0, 1'b0, 32'h208);
        idle(1'b1, 1'b0, 32'h206);
        drain_all();

        // uncached store held at the port for five cycles
        st(32'h500, 32'hCAFE, 1'b1, 1'b0, 1'b0, 32'h0);
        idle(1'b1, 1'b0, 32'h0);
        for (int k = 0; k < 5; k++) idle(1'b0, 1'b0, 32'h500);
        drain_all();

        // streaming through the wrap, then reset mid-stream
        for (int k = 0; k < 10; k++) st(32'h600 + 4 * k, 32'h3000 + k, 1'b0, 1'b1, 1'b1, 32'h600 + 4 * k);
        drain_all();
        for (int k = 0; k < 3; k++) st(32'h700 + 4 * k, 32'h4000 + k, 1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 32'h700);

        for (int n = 0; n < 3000; n++) begin
            ra = 32'h200 + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
            rq = 32'h200 + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
            step($urandom_range(0, 99) < 60, ra, $urandom, 4'($urandom), 2'($urandom),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 5,
                 $urandom_range(0, 299) == 0, rq);
        end
        drain_all();
        chk("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
